// File: rtl/fwd_exec_pipe_if.sv
// Issue, retire and debug signals of the forwarding execute pipe.
interface fwd_exec_pipe_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int IMM_WIDTH  = 20,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic [ADDR_WIDTH-1:0] in_rs1;
  logic [ADDR_WIDTH-1:0] in_rs2;
  logic [IMM_WIDTH-1:0]  in_imm;
  logic                  wb_valid;
  logic                  wb_ready;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [WIDTH-1:0]      wb_data;
  logic [CNT_WIDTH-1:0]  retired;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [WIDTH-1:0]      dbg_data;

  // Instruction source / retire consumer side.
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, wb_ready, dbg_addr,
    input  in_ready, wb_valid, wb_we, wb_rd, wb_data, retired, dbg_data
  );

  // Pipe side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, wb_ready, dbg_addr,
    output in_ready, wb_valid, wb_we, wb_rd, wb_data, retired, dbg_data
  );
endinterface

// File: rtl/fwd_exec_pipe.sv
// Two-stage EX/WB pipe with register file, full operand forwarding,
// hardwired-zero R0, retire counter and a combinational debug read port.
module fwd_exec_pipe #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int IMM_WIDTH  = 20,
  parameter int CNT_WIDTH  = 16
) (
  input logic           clk,
  input logic           rst,
  fwd_exec_pipe_if.slave bus
);
  localparam int NREG = 2**ADDR_WIDTH;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef struct packed {
    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] rd;
    logic [IMM_WIDTH-1:0]  imm;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
  } ex_t;

  ex_t                   ex_q;
  logic [1:0]            vld_pipe;   // [0] = EX occupied, [1] = WB occupied
  logic [WIDTH-1:0]      rf [NREG];
  logic [WIDTH-1:0]      wb_data_q;
  logic [ADDR_WIDTH-1:0] wb_rd_q;
  logic                  wb_we_q;
  logic [CNT_WIDTH-1:0]  ret_q;

  logic                  wb_load, ex_adv, issue, commit, ex_writes;
  logic [WIDTH-1:0]      ex_res, imm_ext;
  logic [1:0][ADDR_WIDTH-1:0] rs;
  logic [1:0][WIDTH-1:0]      opnd;

  assign wb_load      = !vld_pipe[1] || bus.wb_ready;
  assign ex_adv       = vld_pipe[0] && wb_load;
  assign bus.in_ready = !rst && (!vld_pipe[0] || wb_load);
  assign issue        = bus.in_valid && bus.in_ready;
  assign commit       = vld_pipe[1] && bus.wb_ready;
  assign ex_writes    = (ex_q.op != OP_NOP) && (ex_q.rd != '0);

  generate
    if (IMM_WIDTH >= WIDTH) begin : g_imm_trunc
      assign imm_ext = ex_q.imm[WIDTH-1:0];
    end else begin : g_imm_zext
      assign imm_ext = {{(WIDTH-IMM_WIDTH){1'b0}}, ex_q.imm};
    end
  endgenerate

  // Execute: result is purely a function of the EX registers.
  always_comb begin
    ex_res = '0;
    case (ex_q.op)
      OP_ADD:  ex_res = ex_q.a + ex_q.b;
      OP_SUB:  ex_res = ex_q.a - ex_q.b;
      OP_AND:  ex_res = ex_q.a & ex_q.b;
      OP_OR:   ex_res = ex_q.a | ex_q.b;
      OP_XOR:  ex_res = ex_q.a ^ ex_q.b;
      OP_LOAD: ex_res = imm_ext;
      OP_SLT:  ex_res = {{(WIDTH-1){1'b0}}, ($signed(ex_q.a) < $signed(ex_q.b))};
      default: ex_res = '0;
    endcase
  end

  // Operand resolve at issue: R0, then the younger EX result, then WB, then RF.
  always_comb begin
    rs[0] = bus.in_rs1;
    rs[1] = bus.in_rs2;
    for (int i = 0; i < 2; i++) begin
      if (rs[i] == '0)
        opnd[i] = '0;
      else if (vld_pipe[0] && ex_writes && ex_q.rd == rs[i])
        opnd[i] = ex_res;
      else if (vld_pipe[1] && wb_we_q && wb_rd_q == rs[i])
        opnd[i] = wb_data_q;
      else
        opnd[i] = rf[rs[i]];
    end
  end

  // Pipeline stage registers, valid bits and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      vld_pipe  <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      ret_q     <= '0;
    end else begin
      if (issue) begin
        ex_q.op  <= bus.in_op;
        ex_q.rd  <= bus.in_rd;
        ex_q.imm <= bus.in_imm;
        ex_q.a   <= opnd[0];
        ex_q.b   <= opnd[1];
      end
      if (issue)
        vld_pipe[0] <= 1'b1;
      else if (ex_adv)
        vld_pipe[0] <= 1'b0;
      if (ex_adv) begin
        wb_data_q   <= ex_res;
        wb_rd_q     <= ex_q.rd;
        wb_we_q     <= ex_writes;
        vld_pipe[1] <= 1'b1;
      end else if (wb_load) begin
        vld_pipe[1] <= 1'b0;
      end
      if (commit)
        ret_q <= ret_q + 1'b1;
    end
  end

  // Register file commit; R0 is never written so it reads back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (commit && wb_we_q && wb_rd_q != '0) begin
      rf[wb_rd_q] <= wb_data_q;
    end
  end

  assign bus.wb_valid = vld_pipe[1];
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.retired  = ret_q;
  assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : rf[bus.dbg_addr];
endmodule
